// File: rtl/matmul_pkg.sv
// matmul_pkg: shared definitions for the matmul core and its host-side
// initiator.
//   S_FLOAT  - element width of an IEEE-754 single-precision word.
//   ST_*     - host FSM state encoding (LOAD_A, LOAD_B, START, WAIT, DRAIN).
//   elem_lsb - row-major element slice helper. Element k of an n-element flat
//              bus of s-bit words sits at [elem_lsb(k, n, s) +: s], so that
//              element 0 occupies the most significant word.
package matmul_pkg;

  localparam int S_FLOAT = 32;

  localparam logic [2:0] ST_LOAD_A = 3'd0;
  localparam logic [2:0] ST_LOAD_B = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;

  function automatic int elem_lsb(input int k, input int n, input int s);
    return (n - 1 - k) * s;
  endfunction

endpackage

// File: rtl/mat_word_packer.sv
// mat_word_packer: indexed word write into a flat N*S register.
//   clk     - clock, all logic on posedge
//   clr     - synchronous clear of the whole register (active high)
//   wr_en   - write wr_data into element wr_idx this cycle
//   wr_idx  - element index, 0 = most significant word
//   wr_data - word to write
//   flat    - packed row-major register contents
module mat_word_packer
  import matmul_pkg::*;
#(
  parameter int S  = 32,
  parameter int N  = 12,
  parameter int IW = 5
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           wr_en,
  input  logic [IW-1:0]  wr_idx,
  input  logic [S-1:0]   wr_data,
  output logic [N*S-1:0] flat
);

  logic [N*S-1:0] flat_reg;
  logic [N-1:0]   hit;

  // One-hot decode of the write index; an index >= N selects nothing.
  for (genvar gi = 0; gi < N; gi++) begin : g_hit
    assign hit[gi] = wr_en && (wr_idx == IW'(gi));
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      flat_reg <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (hit[k]) begin
          flat_reg[elem_lsb(k, N, S) +: S] <= wr_data;
        end
      end
    end
  end

  assign flat = flat_reg;

endmodule

// File: rtl/matmul_host.sv
// matmul_host: host-side initiator for the matmul core.
// Receives A (H x C) then B (C x W) as a serial word stream, packs them into
// the core's flat row-major buses, pulses mm_start, waits for a rising edge on
// mm_done, captures O (H x W) and streams it back out with a last flag.
//   rst_n, clk           - synchronous active-low reset, single clock
//   in_valid/in_ready    - operand stream handshake, in_data = operand word
//   out_valid/out_ready  - result stream handshake, out_data = result word,
//                          out_last marks the H*W-th word
//   busy                 - low only when idle in LOAD_A with nothing loaded
//   mm_start/mm_a/mm_b   - command and operands to the core
//   mm_o/mm_done         - result and completion flag from the core
module matmul_host
  import matmul_pkg::*;
#(
  parameter int S = S_FLOAT,
  parameter int H = 4,
  parameter int W = 6,
  parameter int C = 3
) (
  input  logic             rst_n,
  input  logic             clk,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [S-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [S-1:0]     out_data,
  output logic             out_last,
  output logic             busy,
  output logic             mm_start,
  output logic [H*C*S-1:0] mm_a,
  output logic [C*W*S-1:0] mm_b,
  input  logic [H*W*S-1:0] mm_o,
  input  logic             mm_done
);

  localparam int NA   = H * C;
  localparam int NB   = C * W;
  localparam int NO   = H * W;
  localparam int NMAX = (NA > NB) ? ((NA > NO) ? NA : NO) : ((NB > NO) ? NB : NO);
  localparam int CW   = $clog2(NMAX + 1);

  logic [2:0]      state_reg;
  logic [CW-1:0]   cnt_reg;
  logic            done_q;
  logic [NO*S-1:0] res_reg;

  logic pk_clr, a_wr, b_wr, done_rise;

  assign pk_clr    = !rst_n;
  assign in_ready  = (state_reg == ST_LOAD_A) || (state_reg == ST_LOAD_B);
  assign a_wr      = (state_reg == ST_LOAD_A) && in_valid;
  assign b_wr      = (state_reg == ST_LOAD_B) && in_valid;
  // A done level already high when WAIT is entered was registered into
  // done_q earlier, so only a fresh low-to-high transition is taken.
  assign done_rise = mm_done && !done_q;
  assign mm_start  = (state_reg == ST_START);
  assign out_valid = (state_reg == ST_DRAIN);
  assign out_last  = out_valid && (cnt_reg == CW'(NO - 1));
  assign busy      = !((state_reg == ST_LOAD_A) && (cnt_reg == '0));

  mat_word_packer #(.S(S), .N(NA), .IW(CW)) u_pack_a (
    .clk     (clk),
    .clr     (pk_clr),
    .wr_en   (a_wr),
    .wr_idx  (cnt_reg),
    .wr_data (in_data),
    .flat    (mm_a)
  );

  mat_word_packer #(.S(S), .N(NB), .IW(CW)) u_pack_b (
    .clk     (clk),
    .clr     (pk_clr),
    .wr_en   (b_wr),
    .wr_idx  (cnt_reg),
    .wr_data (in_data),
    .flat    (mm_b)
  );

  // Result word select; the counter only indexes O while draining, so the
  // selected word is stable whenever out_valid is held against a stall.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < NO; k++) begin
      if (cnt_reg == CW'(k)) begin
        out_data = res_reg[elem_lsb(k, NO, S) +: S];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_LOAD_A;
      cnt_reg   <= '0;
      done_q    <= 1'b0;
      res_reg   <= '0;
    end else begin
      done_q <= mm_done;
      case (state_reg)
        ST_LOAD_A: begin
          if (in_valid) begin
            if (cnt_reg == CW'(NA - 1)) begin
              cnt_reg   <= '0;
              state_reg <= ST_LOAD_B;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        ST_LOAD_B: begin
          if (in_valid) begin
            if (cnt_reg == CW'(NB - 1)) begin
              cnt_reg   <= '0;
              state_reg <= ST_START;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        ST_START: begin
          cnt_reg   <= '0;
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_rise) begin
            res_reg   <= mm_o;
            cnt_reg   <= '0;
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (cnt_reg == CW'(NO - 1)) begin
              cnt_reg   <= '0;
              state_reg <= ST_LOAD_A;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          cnt_reg   <= '0;
          state_reg <= ST_LOAD_A;
        end
      endcase
    end
  end

endmodule
